// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the memory-side bus of the data-memory arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the memory.
interface dmem_arbiter_if #(
  parameter int REGSIZE = 32,
  parameter int ADDRW   = 5
) ();
  logic               req0;
  logic               req1;
  logic               we0;
  logic               we1;
  logic               lock0;
  logic               lock1;
  logic [ADDRW-1:0]   addr0;
  logic [ADDRW-1:0]   addr1;
  logic [REGSIZE-1:0] wdata0;
  logic [REGSIZE-1:0] wdata1;
  logic               gnt0;
  logic               gnt1;
  logic               rvalid0;
  logic               rvalid1;
  logic [REGSIZE-1:0] rdata0;
  logic [REGSIZE-1:0] rdata1;
  logic               mem_read;
  logic               mem_write;
  logic [ADDRW-1:0]   mem_addr;
  logic [REGSIZE-1:0] mem_wdata;
  logic [REGSIZE-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1,
    input  addr0, addr1, wdata0, wdata1,
    input  mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1,
    output addr0, addr1, wdata0, wdata1,
    output mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between two requesters,
// with a bounded lock so the most recent winner can hold the memory for short bursts.
module dmem_arbiter #(
  parameter int REGSIZE  = 32,
  parameter int ADDRW    = 5,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

  logic [1:0]         w_req;
  logic [1:0]         w_we;
  logic [1:0]         w_lock;
  logic [ADDRW-1:0]   w_addr  [2];
  logic [REGSIZE-1:0] w_wdata [2];
  logic [1:0]         w_gnt;
  logic               w_any;
  logic               w_sel;
  logic [HW-1:0]      w_hold_inc;

  logic               r_last;
  logic [HW-1:0]      r_hold_cnt;

  assign w_req      = {bus.req1, bus.req0};
  assign w_we       = {bus.we1, bus.we0};
  assign w_lock     = {bus.lock1, bus.lock0};
  assign w_addr[0]  = bus.addr0;
  assign w_addr[1]  = bus.addr1;
  assign w_wdata[0] = bus.wdata0;
  assign w_wdata[1] = bus.wdata1;

  // Contention: the last winner keeps the memory only while locked and under its hold budget.
  always_comb begin
    w_gnt = 2'b00;
    if (!reset) begin
      if (w_req[0] && w_req[1]) begin
        if (w_lock[r_last] && (r_hold_cnt < HOLD_LIMIT)) begin
          w_gnt[r_last] = 1'b1;
        end else begin
          w_gnt[~r_last] = 1'b1;
        end
      end else begin
        w_gnt = w_req;
      end
    end
  end

  assign w_any = |w_gnt;
  assign w_sel = w_gnt[1];

  assign bus.gnt0      = w_gnt[0];
  assign bus.gnt1      = w_gnt[1];
  assign bus.mem_write = w_any & w_we[w_sel];
  assign bus.mem_read  = w_any & ~w_we[w_sel];
  assign bus.mem_addr  = w_any ? w_addr[w_sel]  : '0;
  assign bus.mem_wdata = w_any ? w_wdata[w_sel] : '0;

  assign w_hold_inc = (r_hold_cnt == HOLD_LIMIT) ? HOLD_LIMIT : (r_hold_cnt + HOLD_ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last     <= 1'b1;
      r_hold_cnt <= '0;
    end else if (w_any) begin
      r_last     <= w_sel;
      r_hold_cnt <= (w_sel == r_last) ? w_hold_inc : HOLD_ONE;
    end else begin
      r_hold_cnt <= '0;
    end
  end

  // Per-port read response: one-cycle valid pulse, data held until the next read by that port.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      logic               r_rvalid;
      logic [REGSIZE-1:0] r_rdata;
      logic               w_rd_gnt;

      assign w_rd_gnt = w_gnt[gi] & ~w_we[gi];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_rvalid <= 1'b0;
          r_rdata  <= '0;
        end else begin
          r_rvalid <= w_rd_gnt;
          if (w_rd_gnt) begin
            r_rdata <= bus.mem_rdata;
          end
        end
      end
    end
  endgenerate

  assign bus.rvalid0 = g_resp[0].r_rvalid;
  assign bus.rvalid1 = g_resp[1].r_rvalid;
  assign bus.rdata0  = g_resp[0].r_rdata;
  assign bus.rdata1  = g_resp[1].r_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: bench-owned 32-word memory, behavioural grant/response model,
// directed scenarios with literal expectations, then a randomized phase.
module tb_dmem_arbiter;
  localparam int REGSIZE  = 32;
  localparam int ADDRW    = 5;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.REGSIZE(REGSIZE), .ADDRW(ADDRW)) bus ();

  dmem_arbiter #(.REGSIZE(REGSIZE), .ADDRW(ADDRW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [32];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0101_0101 * i + 32'h100;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  int checks = 0;
  int failures = 0;

  int          m_last;
  int          m_hold;
  int          m_gnt;
  bit          m_rv [2];
  logic [31:0] m_rd [2];
  int          wait_cnt [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = 1;
    m_hold = 0;
    m_gnt  = -1;
    for (int p = 0; p < 2; p++) begin
      m_rv[p] = 1'b0;
      m_rd[p] = '0;
      wait_cnt[p] = 0;
    end
  endtask

  function automatic bit req_of(int p);
    return (p == 0) ? bus.req0 : bus.req1;
  endfunction
  function automatic bit we_of(int p);
    return (p == 0) ? bus.we0 : bus.we1;
  endfunction
  function automatic logic [4:0] addr_of(int p);
    return (p == 0) ? bus.addr0 : bus.addr1;
  endfunction
  function automatic logic [31:0] wdata_of(int p);
    return (p == 0) ? bus.wdata0 : bus.wdata1;
  endfunction

  // Who should win this cycle, from the request/lock rules and the model's history.
  function automatic int pick();
    bit lk;
    if (!bus.req0 && !bus.req1) return -1;
    if (bus.req0 && !bus.req1) return 0;
    if (bus.req1 && !bus.req0) return 1;
    lk = (m_last == 0) ? bus.lock0 : bus.lock1;
    if (lk && m_hold < MAX_HOLD) return m_last;
    return 1 - m_last;
  endfunction

  task automatic drv(input int p, input bit r, input bit w, input bit l,
                     input logic [4:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = w; bus.lock0 = l; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.lock1 = l; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 5'd0, 32'd0);
    drv(1, 0, 0, 0, 5'd0, 32'd0);
  endtask

  task automatic cycle_begin();
    @(negedge clk);
    m_gnt = pick();
    chk("gnt0", bus.gnt0, m_gnt == 0);
    chk("gnt1", bus.gnt1, m_gnt == 1);
    if (m_gnt >= 0) begin
      chk("mem_read", bus.mem_read, !we_of(m_gnt));
      chk("mem_write", bus.mem_write, we_of(m_gnt));
      chk("mem_addr", bus.mem_addr, addr_of(m_gnt));
      chk("mem_wdata", bus.mem_wdata, wdata_of(m_gnt));
    end else begin
      chk("mem_read_idle", bus.mem_read, 0);
      chk("mem_write_idle", bus.mem_write, 0);
      chk("mem_addr_idle", bus.mem_addr, 0);
      chk("mem_wdata_idle", bus.mem_wdata, 0);
    end
    chk("rvalid0", bus.rvalid0, m_rv[0]);
    chk("rvalid1", bus.rvalid1, m_rv[1]);
    chk("rdata0", bus.rdata0, m_rd[0]);
    chk("rdata1", bus.rdata1, m_rd[1]);
    for (int p = 0; p < 2; p++) begin
      if (req_of(p) && !((p == 0) ? bus.gnt0 : bus.gnt1)) wait_cnt[p]++;
      else wait_cnt[p] = 0;
      if (req_of(p)) chk($sformatf("wait_bound%0d", p), wait_cnt[p] <= MAX_HOLD, 1);
    end
  endtask

  task automatic cycle_end();
    for (int p = 0; p < 2; p++) begin
      m_rv[p] = (m_gnt == p) && !we_of(p);
      if (m_rv[p]) m_rd[p] = mem[addr_of(p)];
    end
    if (m_gnt >= 0) begin
      m_hold = (m_gnt == m_last) ? ((m_hold + 1 > MAX_HOLD) ? MAX_HOLD : m_hold + 1) : 1;
      m_last = m_gnt;
    end else begin
      m_hold = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    idle();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    release_reset();
  endtask

  logic [6:0] lock_pat;
  logic [4:0] fresh_pat;

  initial begin
    model_reset();
    idle();
    drv(0, 1, 0, 0, 5'd3, 32'd0);
    drv(1, 1, 0, 0, 5'd4, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_rvalid0", bus.rvalid0, 0);
    chk("rst_rvalid1", bus.rvalid1, 0);
    chk("rst_rdata0", bus.rdata0, 0);
    chk("rst_mem_read", bus.mem_read, 0);
    release_reset();

    // Port 1 plants a value, port 0 reads it back.
    drv(1, 1, 1, 0, 5'd3, 32'hDEAD_BEEF);
    cycle_begin();
    chk("t1_wr_gnt1", bus.gnt1, 1);
    chk("t1_wr_mem_write", bus.mem_write, 1);
    cycle_end();
    idle();
    drv(0, 1, 0, 0, 5'd3, 32'd0);
    cycle_begin();
    chk("t1_gnt0", bus.gnt0, 1);
    chk("t1_mem_read", bus.mem_read, 1);
    chk("t1_mem_addr", bus.mem_addr, 3);
    cycle_end();
    idle();
    cycle_begin();
    chk("t1_rvalid0", bus.rvalid0, 1);
    chk("t1_rdata0", bus.rdata0, 32'hDEAD_BEEF);
    chk("t1_rvalid1", bus.rvalid1, 0);
    cycle_end();

    // Plain contention alternates starting with port 0.
    apply_reset();
    drv(0, 1, $urandom % 2, 0, 5'd10, $urandom);
    drv(1, 1, $urandom % 2, 0, 5'd11, $urandom);
    for (int k = 0; k < 6; k++) begin
      cycle_begin();
      chk("t2_alternate_gnt0", bus.gnt0, (k % 2) == 0);
      cycle_end();
    end

    // Port 1 writes while port 0 waits on the same address.
    idle();
    drv(0, 1, 0, 0, 5'd0, 32'd0);
    cycle_begin();
    cycle_end();
    drv(0, 1, 0, 0, 5'd7, 32'd0);
    drv(1, 1, 1, 0, 5'd7, 32'h1234_5678);
    cycle_begin();
    chk("t3_gnt1_write", bus.gnt1, 1);
    chk("t3_gnt0_wait", bus.gnt0, 0);
    cycle_end();
    drv(1, 0, 0, 0, 5'd0, 32'd0);
    cycle_begin();
    chk("t3_gnt0_read", bus.gnt0, 1);
    cycle_end();
    idle();
    cycle_begin();
    chk("t3_rvalid0", bus.rvalid0, 1);
    chk("t3_rdata0", bus.rdata0, 32'h1234_5678);
    cycle_end();

    // Locked burst by port 0, bounded by the hold limit.
    apply_reset();
    lock_pat = 7'b0010000;
    drv(0, 1, 0, 1, 5'd1, 32'd0);
    drv(1, 1, 0, 0, 5'd2, 32'd0);
    for (int k = 0; k < 7; k++) begin
      cycle_begin();
      chk("t4_lock_gnt1", bus.gnt1, lock_pat[k]);
      cycle_end();
    end

    // An idle cycle restores the full hold budget.
    idle();
    cycle_begin();
    cycle_end();
    fresh_pat = 5'b10000;
    drv(0, 1, 0, 1, 5'd1, 32'd0);
    drv(1, 1, 0, 0, 5'd2, 32'd0);
    for (int k = 0; k < 5; k++) begin
      cycle_begin();
      chk("t5_fresh_gnt1", bus.gnt1, fresh_pat[k]);
      cycle_end();
    end

    // Reset right after a granted read kills the pending response.
    idle();
    drv(0, 1, 0, 0, 5'd3, 32'd0);
    cycle_begin();
    cycle_end();
    chk("t6_rvalid0_before", bus.rvalid0, 1);
    reset = 1'b1;
    #1;
    chk("t6_rvalid0_cleared", bus.rvalid0, 0);
    chk("t6_rdata0_cleared", bus.rdata0, 0);
    chk("t6_gnt0_in_reset", bus.gnt0, 0);
    release_reset();
    drv(0, 1, 0, 0, 5'd5, 32'd0);
    drv(1, 1, 0, 0, 5'd6, 32'd0);
    cycle_begin();
    chk("t6_first_contention", bus.gnt0, 1);
    cycle_end();

    // Randomized traffic; a refused requester holds its request fields.
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(req_of(p) && m_gnt != p)) begin
          drv(p, ($urandom % 5) != 0, $urandom % 2, $urandom % 2,
              (($urandom % 4) == 0) ? 5'($urandom % 32) : 5'($urandom % 8), $urandom);
        end else begin
          if (p == 0) bus.lock0 = $urandom % 2;
          else bus.lock1 = $urandom % 2;
        end
      end
      cycle_begin();
      cycle_end();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
